// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and parity helper
package uart_pkg;
   localparam int BIT_CLOCKS_DEF = 5210;
   localparam int HALF_BIT_CLOCKS_DEF = BIT_CLOCKS_DEF / 2;
   localparam int DATA_BITS = 8;
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } rx_state_e;
   function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
      return ~^d;
   endfunction
endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: bit-period timer flagging half-bit and full-bit points
module uart_baud_timer #(
   parameter int BIT_CLOCKS = 5210,
   parameter int HALF_BIT_CLOCKS = BIT_CLOCKS / 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic half_done,
   output logic bit_done
);
   logic [12:0] cnt_q, cnt_d;
   assign half_done = cnt_q == 13'(HALF_BIT_CLOCKS - 1);
   assign bit_done  = cnt_q == 13'(BIT_CLOCKS - 1);
   // restart on request and wrap at the end of every bit period
   always_comb cnt_d = (clr || bit_done) ? '0 : cnt_q + 13'd1;
   // count register
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/rx.sv
// rx: 8O1 serial receiver sampling at mid-bit, with parity and framing status
module rx
   import uart_pkg::*;
#(
   parameter int BIT_CLOCKS = BIT_CLOCKS_DEF,
   parameter int HALF_BIT_CLOCKS = BIT_CLOCKS / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] dout,
   output logic       data_strobe,
   output logic       parity_error,
   output logic       framing_error,
   output logic       busy
);
   logic       sync1_q, rxs_q;
   logic       half_done, bit_done, clr_timer, last_bit;
   rx_state_e  state_q;
   logic [2:0] bit_cnt_q;
   logic [8:0] sr_q;
   logic [7:0] dout_q;
   logic       strobe_q, perr_q, fe_q, busy_q;
   assign dout          = dout_q;
   assign data_strobe   = strobe_q;
   assign parity_error  = perr_q;
   assign framing_error = fe_q;
   assign busy          = busy_q;
   assign last_bit      = bit_cnt_q == 3'(DATA_BITS - 1);
   assign clr_timer     = (state_q == S_IDLE) || (state_q == S_START && half_done);
   // two-flop synchronizer, idles high so reset never looks like a start bit
   always_ff @(posedge clk)
      if (rst) {sync1_q, rxs_q} <= 2'b11;
      else {sync1_q, rxs_q} <= {rx_in, sync1_q};
   uart_baud_timer #(
      .BIT_CLOCKS(BIT_CLOCKS),
      .HALF_BIT_CLOCKS(HALF_BIT_CLOCKS)
   ) u_timer (
      .clk(clk),
      .rst(rst),
      .clr(clr_timer),
      .half_done(half_done),
      .bit_done(bit_done)
   );
   // frame FSM; timer is re-centred on the start bit so later samples fall mid-bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         dout_q    <= '0;
         strobe_q  <= 1'b0;
         perr_q    <= 1'b0;
         fe_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         fe_q     <= 1'b0;
         case (state_q)
            S_IDLE:
               if (!rxs_q) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
               end
            S_START:
               if (half_done) begin
                  if (rxs_q) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
            S_DATA:
               if (bit_done) begin
                  sr_q <= {rxs_q, sr_q[8:1]};
                  if (last_bit) state_q <= S_PARITY;
                  else bit_cnt_q <= bit_cnt_q + 3'd1;
               end
            S_PARITY:
               if (bit_done) begin
                  sr_q    <= {rxs_q, sr_q[8:1]};
                  state_q <= S_STOP;
               end
            S_STOP:
               if (bit_done) begin
                  if (rxs_q) begin
                     dout_q   <= sr_q[7:0];
                     perr_q   <= sr_q[8] != odd_parity(sr_q[7:0]);
                     strobe_q <= 1'b1;
                     state_q  <= S_IDLE;
                     busy_q   <= 1'b0;
                  end else begin
                     fe_q    <= 1'b1;
                     state_q <= S_BREAK;
                  end
               end
            S_BREAK:
               if (rxs_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rx.sv
// tb_rx: bit-banged frames checked against an 8O1 frame model
module tb_rx;
   localparam int B = 16;
   localparam int H = B / 2;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] dout;
   logic       data_strobe, parity_error, framing_error, busy;
   int         checks = 0;
   int         errors = 0;
   int         fe_cnt = 0;
   int         both_cnt = 0;
   int         fe_base = 0;
   logic       busy_seen = 1'b0;
   logic [8:0] rq[$];
   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      logic       exp_stb;
      logic [7:0] exp_dout;
      logic       exp_perr;
      logic       exp_fe;
   } vec_t;
   vec_t vec[7];

   rx #(.BIT_CLOCKS(B), .HALF_BIT_CLOCKS(H)) dut (
      .clk(clk),
      .rst(rst),
      .rx_in(rx_in),
      .dout(dout),
      .data_strobe(data_strobe),
      .parity_error(parity_error),
      .framing_error(framing_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_strobe) rq.push_back({parity_error, dout});
      if (framing_error) fe_cnt++;
      if (data_strobe && framing_error) both_cnt++;
      if (busy) busy_seen = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int extra_low, input int gap);
      drive(1'b0, B);
      for (int i = 0; i < 8; i++) drive(d[i], B);
      drive(p, B);
      drive(s, B);
      if (!s) drive(1'b0, extra_low * B);
      drive(1'b1, gap * B);
   endtask

   task automatic check_result(input string name, input logic exp_stb, input logic [7:0] exp_dout,
                               input logic exp_perr, input logic exp_fe);
      #1;
      check({name, ".strobes"}, rq.size(), {31'd0, exp_stb});
      if (exp_stb && rq.size() > 0) begin
         check({name, ".dout"}, {24'd0, rq[0][7:0]}, {24'd0, exp_dout});
         check({name, ".perr"}, {31'd0, rq[0][8]}, {31'd0, exp_perr});
      end
      check({name, ".ferr"}, fe_cnt - fe_base, {31'd0, exp_fe});
      rq.delete();
      fe_base = fe_cnt;
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s;
      int         extra;
      vec[0] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vec[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
      vec[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vec[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vec[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      vec[5] = '{8'h6E, 1'b1, 1'b1, 1'b1, 8'h6E, 1'b1, 1'b0};
      vec[6] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

      repeat (5) @(negedge clk);
      check("rst.dout", {24'd0, dout}, 32'd0);
      check("rst.strobe", {31'd0, data_strobe}, 32'd0);
      check("rst.perr", {31'd0, parity_error}, 32'd0);
      check("rst.ferr", {31'd0, framing_error}, 32'd0);
      check("rst.busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (2000) @(negedge clk);
      check_result("idle", 1'b0, 8'h00, 1'b0, 1'b0);

      send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
      send_frame(8'h3C, 1'b1, 1'b1, 0, 2);
      #1;
      check("b2b.strobes", rq.size(), 32'd2);
      if (rq.size() == 2) begin
         check("b2b.first", {23'd0, rq[0]}, 32'h0A5);
         check("b2b.second", {23'd0, rq[1]}, 32'h03C);
      end
      check("b2b.ferr", fe_cnt - fe_base, 32'd0);
      rq.delete();
      fe_base = fe_cnt;

      for (int i = 0; i < 7; i++) begin
         send_frame(vec[i].d, vec[i].p, vec[i].s, 1, 2);
         check_result($sformatf("vec%0d", i), vec[i].exp_stb, vec[i].exp_dout, vec[i].exp_perr, vec[i].exp_fe);
      end

      busy_seen = 1'b0;
      drive(1'b0, 4);
      drive(1'b1, H + 3);
      check("glitch.busy_seen", {31'd0, busy_seen}, 32'd1);
      check("glitch.busy", {31'd0, busy}, 32'd0);
      drive(1'b1, B);
      check_result("glitch", 1'b0, 8'h00, 1'b0, 1'b0);

      send_frame(8'h55, 1'b1, 1'b0, 3, 0);
      check("break.busy_low", {31'd0, busy}, 32'd1);
      check_result("break", 1'b0, 8'h00, 1'b0, 1'b1);
      drive(1'b1, 2 * B);
      check("break.busy_released", {31'd0, busy}, 32'd0);
      send_frame(8'h0F, 1'b1, 1'b1, 0, 2);
      check_result("after_break", 1'b1, 8'h0F, 1'b0, 1'b0);

      drive(1'b0, B);
      drive(1'b1, 4 * B + H);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8 * B);
      check("midrst.busy", {31'd0, busy}, 32'd0);
      check_result("midrst", 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 0, 2);
      check_result("after_rst", 1'b1, 8'hFF, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         d = 8'($urandom);
         p = 1'($urandom);
         s = $urandom_range(0, 6) != 0;
         extra = $urandom_range(0, 2);
         send_frame(d, p, s, extra, $urandom_range(1, 2));
         check_result($sformatf("rand%0d", n), s, d, s && ($countones({p, d}) % 2 == 0), !s);
      end

      check("strobe_and_ferr_overlap", both_cnt, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
